// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding imem request at a time
// and feeds {instr, pc, valid} to the F/D register. Optional macro: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        adel_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic              slot_ok;
  logic              consume;

  assign slot_ok = !valid_o || !stall_i;
  assign consume = valid_o && !stall_i;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  logic adel_q;

  assign misaligned  = fetch_pc[1:0] != 2'b00;
  assign imem_addr_o = fetch_pc;
  assign adel_o      = adel_q;
  // A misaligned PC never reaches memory; the error is reported through the slot instead.
  assign imem_req_o  = !reset && (state == FETCH) && slot_ok && !redirect_i && !misaligned;
`else
  assign imem_addr_o = {fetch_pc[XLEN-1:2], 2'b00};
  assign adel_o      = 1'b0;
  assign imem_req_o  = !reset && (state == FETCH) && slot_ok && !redirect_i;
`endif

  // Fetch FSM, fetch PC and the single-entry output slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      instr_o  <= '0;
      pc_o     <= RESET_PC;
      valid_o  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q   <= 1'b0;
`endif
    end else if (redirect_i) begin
      // Redirect beats stall, gnt and rvalid; an in-flight request must still be drained.
      fetch_pc <= redirect_pc_i;
      instr_o  <= '0;
      valid_o  <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_q   <= 1'b0;
`endif
      case (state)
        FETCH:   state <= FETCH;
        WAIT:    state <= imem_rvalid_i ? FETCH : DRAIN;
        DRAIN:   state <= DRAIN;
        default: state <= FETCH;
      endcase
    end else begin
      if (consume) begin
        valid_o <= 1'b0;
        instr_o <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
        adel_q  <= 1'b0;
`endif
      end
      case (state)
        FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (slot_ok && misaligned) begin
            instr_o <= '0;
            pc_o    <= fetch_pc;
            valid_o <= 1'b1;
            adel_q  <= 1'b1;
          end else if (imem_req_o && imem_gnt_i) begin
            state <= WAIT;
          end
`else
          if (imem_req_o && imem_gnt_i) begin
            state <= WAIT;
          end
`endif
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            instr_o  <= imem_rdata_i;
            pc_o     <= fetch_pc;
            valid_o  <= 1'b1;
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            state    <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_rvalid_i) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
